// File: rtl/sm4_core_arbiter_if.sv
// sm4_core_arbiter_if: request/response channels and core-side bus of the SM4 arbiter
interface sm4_core_arbiter_if;
  logic         req0_valid;
  logic [127:0] req0_plaintext;
  logic [127:0] req0_key;
  logic         req0_ready;
  logic         req1_valid;
  logic [127:0] req1_plaintext;
  logic [127:0] req1_key;
  logic         req1_ready;
  logic         rsp0_valid;
  logic [127:0] rsp0_data;
  logic         rsp0_err;
  logic         rsp0_ready;
  logic         rsp1_valid;
  logic [127:0] rsp1_data;
  logic         rsp1_err;
  logic         rsp1_ready;
  logic [127:0] core_plaintext;
  logic [127:0] core_key;
  logic         core_in_valid;
  logic [127:0] core_result;
  logic         core_out_valid;
  logic         busy;
  modport slave (
    input  req0_valid, req0_plaintext, req0_key, req1_valid, req1_plaintext, req1_key,
    input  rsp0_ready, rsp1_ready, core_result, core_out_valid,
    output req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp0_err, rsp1_valid, rsp1_data, rsp1_err,
    output core_plaintext, core_key, core_in_valid, busy
  );
  modport master (
    output req0_valid, req0_plaintext, req0_key, req1_valid, req1_plaintext, req1_key,
    output rsp0_ready, rsp1_ready, core_result, core_out_valid,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp0_err, rsp1_valid, rsp1_data, rsp1_err,
    input  core_plaintext, core_key, core_in_valid, busy
  );
endinterface

// File: rtl/sm4_core_arbiter.sv
// sm4_core_arbiter: round-robin sharing of one iterative SM4 core between two requesters
module sm4_core_arbiter #(
  parameter int CORE_TIMEOUT = 40
) (
  input logic clk,
  input logic reset,
  sm4_core_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic last_grant, owner, win, any_req, tmo, err_q;
  logic [5:0] timer;
  logic [127:0] pt_q, key_q, res_q;
  always_comb begin
    any_req = bus.req0_valid | bus.req1_valid;
    win = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    tmo = timer + 6'd1 == 6'(CORE_TIMEOUT);
    state_n = state == IDLE ? (any_req ? RUN : IDLE) :
              state == RUN  ? ((bus.core_out_valid | tmo) ? DONE : RUN) :
              ((owner ? bus.rsp1_ready : bus.rsp0_ready) ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      owner <= 1'b0;
      timer <= '0;
      pt_q <= '0;
      key_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        owner <= win;
        last_grant <= win;
        pt_q <= win ? bus.req1_plaintext : bus.req0_plaintext;
        key_q <= win ? bus.req1_key : bus.req0_key;
        timer <= '0;
      end
      // a core result wins over a timeout landing in the same cycle
      if (state == RUN) begin
        timer <= timer + 6'd1;
        if (bus.core_out_valid) begin
          res_q <= bus.core_result;
          err_q <= 1'b0;
        end else if (tmo) begin
          res_q <= '0;
          err_q <= 1'b1;
        end
      end
    end
  end
  assign bus.req0_ready = state == IDLE && any_req && !win;
  assign bus.req1_ready = state == IDLE && any_req && win;
  assign bus.core_in_valid = state == RUN;
  assign bus.core_plaintext = pt_q;
  assign bus.core_key = key_q;
  assign bus.rsp0_valid = state == DONE && !owner;
  assign bus.rsp1_valid = state == DONE && owner;
  assign bus.rsp0_data = res_q;
  assign bus.rsp1_data = res_q;
  assign bus.rsp0_err = err_q;
  assign bus.rsp1_err = err_q;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_sm4_core_arbiter.sv
// tb_sm4_core_arbiter: transaction-level model plus SM4 reference core stub around the arbiter
module tb_sm4_core_arbiter;
  localparam int TO = 40;
  localparam logic [127:0] GV = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] GC = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48};

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction
  function automatic logic [127:0] sm4_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0] k [36];
    logic [31:0] x [36];
    logic [31:0] t, ck;
    for (int i = 0; i < 4; i++) begin
      k[i] = key[127-32*i -: 32] ^ FK[i];
      x[i] = pt[127-32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i+j)*7) % 256);
      t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
      t = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[i+4]);
      x[i+4] = x[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  logic clk = 1'b0;
  logic reset = 1'b1;
  sm4_core_arbiter_if b();
  sm4_core_arbiter #(.CORE_TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(b.slave));
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference core: result on the 32nd cycle after in_valid rises, or at a chosen cycle, or never
  logic [5:0] scnt = '0;
  bit stub_never = 1'b0;
  int stub_at = 32;
  always @(posedge clk) scnt <= !b.core_in_valid ? 6'd0 : (scnt == 6'd63 ? scnt : scnt + 6'd1);
  assign b.core_out_valid = b.core_in_valid && !stub_never && int'(scnt) == stub_at;
  assign b.core_result = sm4_enc(b.core_plaintext, b.core_key);

  int n_chk = 0, n_pass = 0;
  task automatic tally(input bit ok, input string msg);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    tally(act === exp, $sformatf("%s: got %b expected %b", nm, act, exp));
  endtask
  task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tally(act === exp, $sformatf("%s: got %h expected %h", nm, act, exp));
  endtask
  task automatic chki(input string nm, input int act, input int exp);
    tally(act == exp, $sformatf("%s: got %0d expected %0d", nm, act, exp));
  endtask

  // job-level model: one outstanding job, timed from its grant cycle
  bit chk_en = 1'b0;
  bit m_act = 1'b0, m_own = 1'b0, m_last = 1'b1, m_err = 1'b0;
  int m_t = 0, m_fin = 0;
  logic [127:0] m_pt = '0, m_key = '0, m_res = '0;
  always @(negedge clk) if (chk_en) begin
    bit g, w, dn;
    int oc;
    g = !m_act && (b.req0_valid || b.req1_valid);
    w = (b.req0_valid && b.req1_valid) ? !m_last : b.req1_valid;
    dn = m_act && m_t >= m_fin;
    chk1("req0_ready", b.req0_ready, g && !w);
    chk1("req1_ready", b.req1_ready, g && w);
    chk1("busy", b.busy, m_act);
    chk1("core_in_valid", b.core_in_valid, m_act && !dn);
    chkw("core_plaintext", b.core_plaintext, m_pt);
    chkw("core_key", b.core_key, m_key);
    chk1("rsp0_valid", b.rsp0_valid, dn && !m_own);
    chk1("rsp1_valid", b.rsp1_valid, dn && m_own);
    if (dn) begin
      chkw("rsp_data", m_own ? b.rsp1_data : b.rsp0_data, m_res);
      chk1("rsp_err", m_own ? b.rsp1_err : b.rsp0_err, m_err);
    end
    if (reset) begin
      m_act = 0; m_last = 1; m_pt = '0; m_key = '0;
    end else if (g) begin
      m_act = 1; m_t = 1; m_own = w; m_last = w;
      m_pt = w ? b.req1_plaintext : b.req0_plaintext;
      m_key = w ? b.req1_key : b.req0_key;
      oc = stub_never ? 1000 : stub_at + 1;
      m_err = oc > TO;
      m_fin = (m_err ? TO : oc) + 1;
      m_res = m_err ? '0 : sm4_enc(m_pt, m_key);
    end else if (dn && (m_own ? b.rsp1_ready : b.rsp0_ready)) m_act = 0;
    else if (m_act) m_t++;
  end

  int gcyc = 0;
  task automatic wait_grant(input bit ch, input string nm);
    int k = 0;
    @(negedge clk);
    while (!(ch ? b.req1_ready : b.req0_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk1(nm, ch ? b.req1_ready : b.req0_ready, 1'b1);
    gcyc = cyc;
  endtask
  task automatic wait_rsp(input bit ch, input string nm, output int lat);
    int k = 0;
    @(negedge clk);
    while (!(ch ? b.rsp1_valid : b.rsp0_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk1(nm, ch ? b.rsp1_valid : b.rsp0_valid, 1'b1);
    lat = cyc - gcyc;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, k;
    logic [3:0] ord;
    logic [127:0] d;
    bit seen;
    b.req0_valid = 0; b.req1_valid = 0;
    b.req0_plaintext = '0; b.req0_key = '0; b.req1_plaintext = '0; b.req1_key = '0;
    b.rsp0_ready = 1; b.rsp1_ready = 1;
    chkw("sm4_model_golden", sm4_enc(GV, GV), GC);
    repeat (2) step();
    chk_en = 1;
    @(negedge clk);
    chk1("rst_busy", b.busy, 1'b0);
    chk1("rst_rsp0_valid", b.rsp0_valid, 1'b0);
    chkw("rst_rsp0_data", b.rsp0_data, '0);
    chk1("rst_rsp1_err", b.rsp1_err, 1'b0);
    chkw("rst_core_key", b.core_key, '0);
    step();
    reset = 0;
    // single job on channel 0, inputs changed right after the grant
    b.req0_valid = 1; b.req0_plaintext = GV; b.req0_key = GV;
    wait_grant(0, "t1_grant");
    step();
    b.req0_valid = 0; b.req0_plaintext = '1; b.req0_key = '0;
    wait_rsp(0, "t1_rsp", lat);
    chki("t1_latency", lat, 34);
    chkw("t1_data", b.rsp0_data, GC);
    chk1("t1_err", b.rsp0_err, 1'b0);
    chk1("t1_rsp1_quiet", b.rsp1_valid, 1'b0);
    // both request at reset release, kept requesting: grants alternate 0,1,0,1
    step();
    reset = 1;
    step();
    reset = 0;
    b.req0_valid = 1; b.req0_plaintext = 128'h11; b.req0_key = 128'haa;
    b.req1_valid = 1; b.req1_plaintext = 128'h22; b.req1_key = 128'hbb;
    ord = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      @(negedge clk);
      while (!(b.req0_ready || b.req1_ready) && k < 100) begin
        @(negedge clk);
        k++;
      end
      chk1("rr_grant_seen", b.req0_ready || b.req1_ready, 1'b1);
      chk1("rr_order", b.req1_ready, ord[i]);
      if (i > 0) chki("issue_interval", cyc - gcyc, 35);
      gcyc = cyc;
      step();
      if (ord[i]) b.req1_key = b.req1_key + 128'h1357;
      else b.req0_plaintext = {b.req0_plaintext[126:0], b.req0_plaintext[127]} ^ 128'hf00d;
    end
    b.req0_valid = 0; b.req1_valid = 0;
    wait_rsp(1, "t2_last_rsp", lat);
    chki("t2_latency", lat, 34);
    // backpressure on channel 1 while channel 0 waits
    step();
    b.rsp1_ready = 0;
    b.req1_valid = 1; b.req1_plaintext = GV; b.req1_key = 128'hdeadbeef;
    wait_grant(1, "t3_grant");
    step();
    b.req1_valid = 0;
    b.req0_valid = 1; b.req0_plaintext = 128'h5555; b.req0_key = GV;
    wait_rsp(1, "t3_rsp", lat);
    d = b.rsp1_data;
    chkw("t3_data", d, sm4_enc(GV, 128'hdeadbeef));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk1("bp_valid_held", b.rsp1_valid, 1'b1);
      chkw("bp_data_stable", b.rsp1_data, d);
      chk1("bp_core_idle", b.core_in_valid, 1'b0);
      chk1("bp_no_grant", b.req0_ready, 1'b0);
    end
    step();
    b.rsp1_ready = 1;
    @(negedge clk);
    chk1("bp_handshake_no_grant", b.req0_ready, 1'b0);
    @(negedge clk);
    chk1("bp_grant_after", b.req0_ready, 1'b1);
    gcyc = cyc;
    step();
    b.req0_valid = 0;
    wait_rsp(0, "t3_rsp0", lat);
    chki("t3_rsp0_latency", lat, 34);
    // timeout with a silent core, then a normal job
    step();
    stub_never = 1;
    b.req0_valid = 1; b.req0_plaintext = 128'h77; b.req0_key = 128'h88;
    wait_grant(0, "t4_grant");
    step();
    b.req0_valid = 0;
    wait_rsp(0, "t4_rsp", lat);
    chki("t4_timeout_latency", lat, TO + 1);
    chk1("t4_err", b.rsp0_err, 1'b1);
    chkw("t4_data_zero", b.rsp0_data, '0);
    step();
    stub_never = 0;
    b.req1_valid = 1; b.req1_plaintext = 128'h99; b.req1_key = GV;
    wait_grant(1, "t4b_grant");
    step();
    b.req1_valid = 0;
    wait_rsp(1, "t4b_rsp", lat);
    chki("t4b_latency", lat, 34);
    chk1("t4b_err", b.rsp1_err, 1'b0);
    // reset on run cycle 15 drops the job without a response
    step();
    b.req0_valid = 1; b.req0_plaintext = 128'habc; b.req0_key = 128'hdef;
    wait_grant(0, "t5_grant");
    step();
    b.req0_valid = 0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk1("t5_busy_cleared", b.busy, 1'b0);
    chk1("t5_core_dropped", b.core_in_valid, 1'b0);
    chkw("t5_core_pt_cleared", b.core_plaintext, '0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= b.rsp0_valid | b.rsp1_valid;
    end
    chk1("t5_no_rsp", seen, 1'b0);
    step();
    b.req0_valid = 1; b.req0_plaintext = GV; b.req0_key = 128'h1;
    wait_grant(0, "t5b_grant");
    step();
    b.req0_valid = 0;
    wait_rsp(0, "t5b_rsp", lat);
    chki("t5b_latency", lat, 34);
    chkw("t5b_data", b.rsp0_data, sm4_enc(GV, 128'h1));
    // core result in the very cycle the watchdog expires
    step();
    stub_at = TO - 1;
    b.req1_valid = 1; b.req1_plaintext = 128'h4242; b.req1_key = GV;
    wait_grant(1, "t6_grant");
    step();
    b.req1_valid = 0;
    wait_rsp(1, "t6_rsp", lat);
    chki("t6_latency", lat, TO + 1);
    chk1("t6_err", b.rsp1_err, 1'b0);
    chkw("t6_data", b.rsp1_data, sm4_enc(128'h4242, GV));
    step();
    stub_at = 32;
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sm4_core_arbiter.md
# sm4_core_arbiter

Round-robin scheduler that shares one iterative 32-round SM4 core (`cir_top`) between two independent requesters. It accepts plaintext/key pairs from each channel, drives the core's start protocol, captures the result, and returns it on the originating channel's response port with valid/ready backpressure. A watchdog bounds every core run. The block sits between the system interconnect and the single SM4 datapath instance.

## Interface
- CORE_TIMEOUT, 40: maximum cycles in RUN before abort; legal range 33..63 (6-bit counter).
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- reqN_valid  in  1  channel N (N=0,1) has a job.
- reqN_plaintext  in  128  channel N plaintext.
- reqN_key  in  128  channel N user key.
- reqN_ready  out  1  one-cycle accept pulse for channel N.
- rspN_valid  out  1  channel N result available.
- rspN_data  out  128  channel N ciphertext; zero on error.
- rspN_err  out  1  channel N job timed out; qualified by rspN_valid.
- rspN_ready  in  1  channel N consumes the response.
- core_plaintext  out  128  to core plaintext_in.
- core_key  out  128  to core key_in.
- core_in_valid  out  1  to core in_valid.
- core_result  in  128  from core result_out.
- core_out_valid  in  1  from core out_valid.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: core_in_valid=0. If any reqN_valid, select a winner, pulse its reqN_ready for that cycle, latch its plaintext/key into job registers, record owner, clear timer, go to RUN.
- Arbitration: round-robin with a 1-bit last_grant pointer. With one requester, it wins. With both, the channel not equal to last_grant wins. last_grant updates on every grant. Reset value is 1, so channel 0 wins the first tie.
- RUN: core_in_valid=1 continuously. core_plaintext/core_key are driven from the job registers only, so they are stable for the whole run. The timer increments each cycle.
  - On core_out_valid: capture core_result, set err=0, go to DONE.
  - Else, if the timer reaches CORE_TIMEOUT: set result=0, err=1, go to DONE.
  - core_out_valid has priority when both occur in the same cycle.
- DONE: core_in_valid=0. Every DONE dwell therefore gives the core at least one low cycle, which it needs before the next rising edge restarts it.
  - rspN_valid=1 for the owner only. rspN_data/rspN_err come from capture registers and are stable while valid.
  - When rspN_ready=1 for the owner: go to IDLE.
  - rsp of the non-owner stays 0.
- core_out_valid outside RUN is ignored.
- A new request is never accepted while busy. reqN_valid held during that time is simply stalled.
- Request inputs are sampled only on the grant cycle, so requesters may change data after the ready pulse.

## Timing
- Reset values: state=IDLE, reqN_ready=0, rspN_valid=0, rspN_data=0, rspN_err=0, core_in_valid=0, core_plaintext=0, core_key=0, busy=0, last_grant=1, timer=0.
- Reset asserted in any state returns to IDLE on that edge. It drops core_in_valid, which aborts the core's count, and discards any pending response without delivering it.
- Grant cycle is cycle 0, with reqN_ready high. core_in_valid rises on cycle 1.
- The core asserts core_out_valid nominally 32 cycles after core_in_valid rises, on cycle 33. rspN_valid rises on cycle 34.
- With rsp_ready held high, DONE lasts 1 cycle, IDLE is re-entered on cycle 35, and the next grant can occur on cycle 35. Minimum issue interval is 35 cycles.
- Timeout: if no core_out_valid arrives, DONE is entered CORE_TIMEOUT cycles after core_in_valid rises.
- reqN_ready is combinational from state==IDLE and arbitration. It is never high outside IDLE.

## Test plan
- Single job, ch0, with the real core: plaintext=key=0123456789abcdeffedcba9876543210 -> req0_ready pulses on cycle 0; rsp0_valid rises on cycle 34 with rsp0_data=681edf34d206965e86b3e94f536e4246 and rsp0_err=0; rsp1_valid stays 0.
- Both channels request at reset release, with distinct keys -> ch0 is served first, then ch1. With both still requesting afterwards, the grants alternate 0,1,0,1. Each response matches a golden SM4 model.
- Backpressure: hold rsp1_ready=0 for 20 cycles after rsp1_valid -> rsp1_valid and rsp1_data stay stable; core_in_valid stays 0; req0 is not granted until the cycle after the rsp1 handshake.
- Timeout: stub core that never asserts core_out_valid, CORE_TIMEOUT=40 -> DONE is entered 40 cycles after core_in_valid rises; rsp0_err=1 and rsp0_data=0; the next job runs normally.
- Reset mid-run: assert reset on cycle 15 of RUN -> all outputs take their reset values on the next edge; no response is delivered; a fresh request afterwards completes correctly.
- Simultaneous events: stub core asserts core_out_valid in the same cycle the timer hits CORE_TIMEOUT -> result is captured with err=0.
